apb_req_arbiter: RTL and testbench

Two-port arbiter that shares the single APB master interface of the AHB-APB bridge between two internal requesters, such as the AHB-side bridge controller path and a debug/configuration engine. It grants requesters round-robin, sequences each transfer through APB SETUP and ACCESS phases with Pready wait states, and decodes the slave select. It also returns read data and status to the owning requester. A per-transfer timeout and address-decode error path ensure that neither requester can hang the bus.

---
 rtl/apb_req_arbiter.sv | 103 ++++++++++
 tb/tb_apb_req_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin two-requester front end for one APB master port.
module apb_req_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic        err,
  output logic [2:0]  Pselx,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  input  logic [31:0] Prdata,
  input  logic        Pready,
  input  logic        Pslverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);
  state_t      state;
  logic        last;
  logic        owner;
  logic [7:0]  cnt;
  logic [31:0] g_addr;
  logic [2:0]  g_sel;
  // last holds the most recent owner, so a tie goes to the other requester
  always_comb begin
    ack0   = state == IDLE && req0 && (!req1 || last);
    ack1   = state == IDLE && req1 && (!req0 || !last);
    g_addr = ack1 ? addr1 : addr0;
    g_sel  = g_addr[31:28] != 4'h8 ? 3'b000 :
             g_addr[27:26] == 2'd0 ? 3'b001 :
             g_addr[27:26] == 2'd1 ? 3'b010 :
             g_addr[27:26] == 2'd2 ? 3'b100 : 3'b000;
  end
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      cnt     <= 8'd0;
      Pselx   <= 3'b000;
      Penable <= 1'b0;
      Pwrite  <= 1'b0;
      Paddr   <= 32'd0;
      Pwdata  <= 32'd0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      rdata   <= 32'd0;
      err     <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: if (ack0 || ack1) begin
          owner <= ack1;
          last  <= ack1;
          if (g_sel != 3'b000) begin
            state  <= SETUP;
            Pselx  <= g_sel;
            Pwrite <= ack1 ? wr1 : wr0;
            Paddr  <= g_addr;
            Pwdata <= ack1 ? wdata1 : wdata0;
          end else begin
            done0 <= ack0;
            done1 <= ack1;
            err   <= 1'b1;
            rdata <= 32'd0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          Penable <= 1'b1;
          cnt     <= 8'd0;
        end
        ACCESS: if (Pready || cnt == TLIM) begin
          state   <= IDLE;
          Pselx   <= 3'b000;
          Penable <= 1'b0;
          done0   <= !owner;
          done1   <= owner;
          err     <= !Pready || Pslverr;
          rdata   <= Pready && !Pwrite ? Prdata : 32'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: randomized requesters and APB slave against a transaction-level model.
module tb_apb_req_arbiter;
  localparam int TO = 16;
  logic        Hclk = 0;
  logic        Hreset = 1;
  logic [1:0]  req = 0;
  logic [1:0]  wr = 0;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] Prdata = 0;
  logic        Pready = 0;
  logic        Pslverr = 0;
  logic        ack0, ack1, done0, done1, err, Penable, Pwrite;
  logic [31:0] rdata, Paddr, Pwdata;
  logic [2:0]  Pselx;
  apb_req_arbiter #(.TIMEOUT(TO)) dut (
    .Hclk(Hclk), .Hreset(Hreset),
    .req0(req[0]), .req1(req[1]), .wr0(wr[0]), .wr1(wr[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .rdata(rdata), .err(err), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
  );
  always #5 Hclk = ~Hclk;
  int n_vec = 0, n_bad = 0, cyc = 0;
  int g_cyc, d_cyc, waits, rst_cnt = 1;
  bit busy = 0, valid = 0, own = 0, mlast = 1, rst_prev = 1, rr_mode = 0;
  bit [1:0] gprev = 0;
  logic [2:0]  esel;
  logic        ewr, eerr;
  logic [31:0] eaddr, ewdata, erdata;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [2:0] decode(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a <= 32'h83FF_FFFF) return 3'b001;
    if (a >= 32'h8400_0000 && a <= 32'h87FF_FFFF) return 3'b010;
    if (a >= 32'h8800_0000 && a <= 32'h8BFF_FFFF) return 3'b100;
    return 3'b000;
  endfunction
  function automatic logic [31:0] rand_addr(input bit valid_only);
    logic [31:0] off = $urandom & 32'h03FF_FFFC;
    int k = valid_only ? $urandom_range(0, 2) : $urandom_range(0, 8);
    case (k)
      0: return 32'h8000_0000 + off;
      1: return 32'h8400_0000 + off;
      2: return 32'h8800_0000 + off;
      3: return 32'h83FF_FFFC;
      4: return 32'h8C00_0000;
      5: return 32'h7FFF_FFFC;
      6: return 32'h9000_0000;
      7: return 32'h8BFF_FFFC;
      default: return $urandom;
    endcase
  endfunction
  task automatic step();
    bit e0, e1, win, acc, x0, x1;
    @(negedge Hclk);
    cyc++;
    if (rst_prev) begin
      check("rst_pselx", 32'(Pselx), 0);
      check("rst_penable", 32'(Penable), 0);
      check("rst_pwrite", 32'(Pwrite), 0);
      check("rst_paddr", Paddr, 0);
      check("rst_pwdata", Pwdata, 0);
      check("rst_done", {done1, done0}, 0);
      check("rst_rdata", rdata, 0);
      check("rst_err", 32'(err), 0);
      busy = 0;
      mlast = 1;
    end else begin
      e0 = busy && cyc == d_cyc && !own;
      e1 = busy && cyc == d_cyc && own;
      check("done0", 32'(done0), 32'(e0));
      check("done1", 32'(done1), 32'(e1));
      if (e0 || e1) begin
        check("rdata", rdata, erdata);
        check("err", 32'(err), 32'(eerr));
        busy = 0;
      end
      win = busy && valid && cyc > g_cyc;
      check("pselx", 32'(Pselx), win ? 32'(esel) : 0);
      check("penable", 32'(Penable), 32'(win && cyc >= g_cyc + 2));
      if (win) begin
        check("paddr", Paddr, eaddr);
        check("pwrite", 32'(Pwrite), 32'(ewr));
        check("pwdata", Pwdata, ewdata);
      end
    end
    Prdata = $urandom;
    Pslverr = 1'($urandom_range(0, 1));
    acc = busy && valid && cyc >= g_cyc + 2;
    if (acc && waits < TO && cyc == g_cyc + 2 + waits) begin
      Pready = 1;
      erdata = ewr ? 32'd0 : Prdata;
      eerr = Pslverr;
    end else begin
      Pready = acc ? 1'b0 : 1'($urandom_range(0, 1));
    end
    if (rst_cnt == 0 && !rr_mode && acc && $urandom_range(0, 29) == 0) rst_cnt = 2;
    Hreset = rst_cnt > 0;
    if (rst_cnt > 0) rst_cnt--;
    for (int i = 0; i < 2; i++) begin
      if (Hreset || gprev[i]) req[i] = 0;
      if (!Hreset && !req[i] && (rr_mode || $urandom_range(0, 3) == 0)) begin
        req[i] = 1;
        wr[i] = 1'($urandom_range(0, 1));
        addr[i] = rand_addr(rr_mode);
        wdata[i] = $urandom;
      end
    end
    gprev = 0;
    x0 = !busy && !Hreset && req[0] && (!req[1] || mlast);
    x1 = !busy && !Hreset && req[1] && (!req[0] || !mlast);
    #1;
    check("ack0", 32'(ack0), 32'(x0));
    check("ack1", 32'(ack1), 32'(x1));
    if (x0 || x1) begin
      own = x1;
      mlast = x1;
      gprev[x1] = 1;
      g_cyc = cyc;
      busy = 1;
      esel = decode(addr[x1]);
      valid = esel != 3'b000;
      ewr = wr[x1];
      eaddr = addr[x1];
      ewdata = wdata[x1];
      case (rr_mode ? 9 : $urandom_range(0, 5))
        0: waits = TO;
        1: waits = TO - 1;
        9: waits = 0;
        default: waits = $urandom_range(0, 3);
      endcase
      if (!valid) begin
        d_cyc = cyc + 1;
        eerr = 1;
        erdata = 0;
      end else if (waits < TO) begin
        d_cyc = cyc + 3 + waits;
      end else begin
        d_cyc = cyc + 2 + TO;
        eerr = 1;
        erdata = 0;
      end
    end
    rst_prev = Hreset;
  endtask
  initial begin
    addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0;
    rr_mode = 1;
    for (int i = 0; i < 40; i++) step();
    rr_mode = 0;
    for (int i = 0; i < 4000; i++) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
